// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl_pkg
// Shared display constants: default scan timing, FSM state encoding, the
// display configuration record held in the shadow/active registers, and the
// digit-suppression rule used by the scan controller.
`timescale 1ns/1ps
package seg_scan_ctrl_pkg;

   localparam int DIV_DEFAULT  = 50000;  // SHOW cycles per digit
   localparam int DEAD_DEFAULT = 2;      // all-off cycles before each digit
   localparam int DATA_W       = 16;     // four hex digits
   localparam int NDIG         = 4;
   localparam int CNT_W        = 20;     // holds DIV-1 for DIV up to 2^20

   typedef enum logic {
      ST_DEAD = 1'b0,
      ST_SHOW = 1'b1
   } scan_state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [NDIG-1:0]   dp;
      logic [NDIG-1:0]   blank;
      logic              lzs;
   } disp_cfg_t;

   // A digit is dark when blanked, or when leading-zero suppression is on and
   // it and every digit to its left are zero. Digit 0 always survives lzs so
   // a zero value still shows "0".
   function automatic logic digit_suppressed(disp_cfg_t cfg, logic [1:0] idx);
      logic upper_zero;
      upper_zero = 1'b1;
      for (int k = 0; k < NDIG; k++) begin
         if (k >= int'(idx) && cfg.data[4*k +: 4] != 4'h0) upper_zero = 1'b0;
      end
      return cfg.blank[idx] | (cfg.lzs & (idx != 2'd0) & upper_zero);
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if
// Host-side load handshake plus display-side scan outputs of seg_scan_ctrl.
//   en, data, dp, blank, lzs, load : host -> controller
//   ready                          : controller -> host (load accepted when 1)
//   an, nibble, dp_n, frame_done   : controller -> display / host
// Modport slave is the controller, master is the host/bench.
`timescale 1ns/1ps
interface seg_scan_ctrl_if;
   import seg_scan_ctrl_pkg::*;

   logic              en;
   logic [DATA_W-1:0] data;
   logic [NDIG-1:0]   dp;
   logic [NDIG-1:0]   blank;
   logic              lzs;
   logic              load;
   logic              ready;
   logic [NDIG-1:0]   an;
   logic [3:0]        nibble;
   logic              dp_n;
   logic              frame_done;

   modport master (
      output en, data, dp, blank, lzs, load,
      input  ready, an, nibble, dp_n, frame_done
   );

   modport slave (
      input  en, data, dp, blank, lzs, load,
      output ready, an, nibble, dp_n, frame_done
   );

endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Four-digit multiplexed 7-segment scan controller. Each digit gets DEAD
// all-anodes-off cycles followed by DIV lit cycles; a frame is four digits.
// New display content is captured into a shadow register through a
// ready/load handshake and only becomes active at a frame boundary (or while
// scanning is disabled), so a frame never mixes old and new content.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : seg_scan_ctrl_if.slave (handshake inputs, an/nibble/dp_n/frame_done)
`timescale 1ns/1ps
module seg_scan_ctrl
   import seg_scan_ctrl_pkg::*;
#(
   parameter int DIV  = DIV_DEFAULT,
   parameter int DEAD = DEAD_DEFAULT
) (
   input logic           clk,
   input logic           rst,
   seg_scan_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD - 1);

   scan_state_t      r_state;
   scan_state_t      w_state_nx;
   logic [1:0]       r_idx;
   logic [1:0]       w_idx_nx;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nx;
   logic             w_phase_end;
   logic             w_boundary;

   logic             r_pending;
   disp_cfg_t        r_act;
   disp_cfg_t        r_shadow;
   logic [3:0]       r_nib_hold;

   logic             w_show;
   logic             w_lit;
   logic [3:0]       w_nib_cur;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_DEAD;
         r_idx   <= 2'd0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_idx   <= w_idx_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_idx_nx    = r_idx;
      w_cnt_nx    = r_cnt;
      w_phase_end = (r_state == ST_DEAD) ? (r_cnt == DEAD_LAST) : (r_cnt == DIV_LAST);
      w_boundary  = bus.en && (r_state == ST_SHOW) && (r_idx == 2'd3) && w_phase_end;
      if (!bus.en) begin
         // Disabled: park at the start of a frame so re-enable begins with DEAD of digit 0.
         w_state_nx = ST_DEAD;
         w_idx_nx   = 2'd0;
         w_cnt_nx   = '0;
      end else if (w_phase_end) begin
         w_cnt_nx = '0;
         if (r_state == ST_DEAD) begin
            w_state_nx = ST_SHOW;
         end else begin
            w_state_nx = ST_DEAD;
            w_idx_nx   = r_idx + 2'd1;
         end
      end else begin
         w_cnt_nx = r_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------- shadow / active registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending <= 1'b0;
         r_act     <= '0;
         r_shadow  <= '0;
      end else if (r_pending && (w_boundary || !bus.en)) begin
         r_act     <= r_shadow;
         r_pending <= 1'b0;
      end else if (bus.load && !r_pending) begin
         r_shadow  <= '{data: bus.data, dp: bus.dp, blank: bus.blank, lzs: bus.lzs};
         r_pending <= 1'b1;
      end
   end

   // ---------------------------------------------------------------- output decode
   assign w_show    = (r_state == ST_SHOW);
   assign w_lit     = w_show && !digit_suppressed(r_act, r_idx);
   assign w_nib_cur = r_act.data[{r_idx, 2'b00} +: 4];

   // nibble keeps the last SHOW value through DEAD so the decoder input is stable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_nib_hold <= 4'h0;
      end else if (w_show) begin
         r_nib_hold <= w_nib_cur;
      end
   end

   assign bus.an         = w_lit ? ~(4'b0001 << r_idx) : 4'b1111;
   assign bus.nibble     = w_show ? w_nib_cur : r_nib_hold;
   assign bus.dp_n       = w_lit ? ~r_act.dp[r_idx] : 1'b1;
   assign bus.ready      = ~r_pending;
   assign bus.frame_done = w_boundary;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
// Bench for seg_scan_ctrl with DIV=4, DEAD=1 (frame period 20 cycles).
// A frame-position model (position 0..19 within the frame, slot = position/5,
// lit when position%5 >= 1) plus a load/commit scoreboard predicts every
// output on every falling edge; directed scenarios add literal expectations.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;
   import seg_scan_ctrl_pkg::*;

   localparam int TDIV  = 4;
   localparam int TDEAD = 1;
   localparam int SLOT  = TDIV + TDEAD;
   localparam int PER   = 4 * SLOT;

   logic clk;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   seg_scan_ctrl_if bus ();

   seg_scan_ctrl #(.DIV(TDIV), .DEAD(TDEAD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   int        m_p    = 0;
   logic      m_pend = 1'b0;
   disp_cfg_t m_act  = '0;
   disp_cfg_t m_sh   = '0;
   logic [3:0] m_nib = 4'h0;

   function automatic bit m_show(int p);
      return (p % SLOT) >= TDEAD;
   endfunction

   function automatic bit m_supp(disp_cfg_t c, int s);
      if (c.blank[s]) return 1'b1;
      if (c.lzs && s > 0 && (c.data >> (4 * s)) == 16'h0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] m_digit(disp_cfg_t c, int s);
      logic [15:0] d;
      d = c.data >> (4 * s);
      return d[3:0];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_p    <= 0;
         m_pend <= 1'b0;
         m_act  <= '0;
         m_sh   <= '0;
         m_nib  <= 4'h0;
      end else begin
         if (m_show(m_p)) m_nib <= m_digit(m_act, m_p / SLOT);
         if (m_pend && (!bus.en || m_p == PER - 1)) begin
            m_act  <= m_sh;
            m_pend <= 1'b0;
         end else if (bus.load && !m_pend) begin
            m_sh   <= '{data: bus.data, dp: bus.dp, blank: bus.blank, lzs: bus.lzs};
            m_pend <= 1'b1;
         end
         m_p <= bus.en ? (m_p + 1) % PER : 0;
      end
   end

   always @(negedge clk) begin
      int         s;
      bit         lit;
      logic [3:0] e_an;
      logic [3:0] e_nib;
      logic       e_dpn;
      s     = m_p / SLOT;
      lit   = m_show(m_p) && !m_supp(m_act, s);
      e_an  = lit ? (4'hF ^ (4'b0001 << s)) : 4'hF;
      e_nib = m_show(m_p) ? m_digit(m_act, s) : m_nib;
      e_dpn = lit ? ~m_act.dp[s] : 1'b1;
      check("model_an", {28'h0, bus.an}, {28'h0, e_an});
      check("model_nibble", {28'h0, bus.nibble}, {28'h0, e_nib});
      check("model_dp_n", {31'h0, bus.dp_n}, {31'h0, e_dpn});
      check("model_ready", {31'h0, bus.ready}, {31'h0, ~m_pend});
      check("model_frame_done", {31'h0, bus.frame_done},
            {31'h0, (bus.en === 1'b1 && m_p == PER - 1)});
   end

   // ---------------------------------------------------------------- directed stimulus
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_fd(output int k);
      k = 0;
      while (bus.frame_done !== 1'b1 && k < 60) begin
         step(1);
         k++;
      end
      if (bus.frame_done !== 1'b1) check("frame_done_timeout", 32'h0, 32'h1);
   endtask

   task automatic to_pos(input int target);
      int k;
      wait_fd(k);
      step(target + 1);
   endtask

   task automatic load_cfg(input logic [15:0] d, input logic [3:0] p,
                           input logic [3:0] b, input logic z);
      bus.data  = d;
      bus.dp    = p;
      bus.blank = b;
      bus.lzs   = z;
      bus.load  = 1'b1;
   endtask

   task automatic chk_disp(input string name, input logic [3:0] an, input logic [3:0] nib);
      check({name, "_an"}, {28'h0, bus.an}, {28'h0, an});
      check({name, "_nibble"}, {28'h0, bus.nibble}, {28'h0, nib});
   endtask

   initial begin
      int k;
      rst       = 1'b1;
      bus.en    = 1'b0;
      bus.data  = 16'h0;
      bus.dp    = 4'h0;
      bus.blank = 4'h0;
      bus.lzs   = 1'b0;
      bus.load  = 1'b0;
      #3;
      chk_disp("reset", 4'hF, 4'h0);
      check("reset_dp_n", {31'h0, bus.dp_n}, 32'h1);
      check("reset_ready", {31'h0, bus.ready}, 32'h1);
      check("reset_frame_done", {31'h0, bus.frame_done}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      step(1);

      // Basic scan of 1234
      bus.en = 1'b1;
      load_cfg(16'h1234, 4'h0, 4'h0, 1'b0);
      step(1);
      bus.load = 1'b0;
      wait_fd(k);
      check("first_fd_cycle", k + 2, PER);
      check("fd_ready_pending", {31'h0, bus.ready}, 32'h0);
      step(1);
      check("ready_after_fd", {31'h0, bus.ready}, 32'h1);
      check("dead0_an", {28'h0, bus.an}, 32'hF);
      step(1);  chk_disp("d0_1234", 4'hE, 4'h4);
      check("d0_dp_n", {31'h0, bus.dp_n}, 32'h1);
      step(4);  chk_disp("dead1_1234", 4'hF, 4'h4);
      step(1);  chk_disp("d1_1234", 4'hD, 4'h3);
      step(5);  chk_disp("d2_1234", 4'hB, 4'h2);
      step(5);  chk_disp("d3_1234", 4'h7, 4'h1);
      wait_fd(k);
      check("fd_period_tail", k, 3);

      // Leading-zero suppression: 0050 with dp on digit 0, then 0000
      step(1);
      load_cfg(16'h0050, 4'b0001, 4'h0, 1'b1);
      step(1);
      bus.load = 1'b0;
      to_pos(1);
      chk_disp("lzs50_d0", 4'hE, 4'h0);
      check("lzs50_d0_dp_n", {31'h0, bus.dp_n}, 32'h0);
      step(5);  chk_disp("lzs50_d1", 4'hD, 4'h5);
      check("lzs50_d1_dp_n", {31'h0, bus.dp_n}, 32'h1);
      step(5);  chk_disp("lzs50_d2", 4'hF, 4'h0);
      step(5);  chk_disp("lzs50_d3", 4'hF, 4'h0);
      load_cfg(16'h0000, 4'h0, 4'h0, 1'b1);
      step(1);
      bus.load = 1'b0;
      to_pos(1);
      chk_disp("lzs00_d0", 4'hE, 4'h0);
      step(5);  check("lzs00_d1_an", {28'h0, bus.an}, 32'hF);
      step(5);  check("lzs00_d2_an", {28'h0, bus.an}, 32'hF);
      step(5);  check("lzs00_d3_an", {28'h0, bus.an}, 32'hF);

      // Second load while pending is ignored; blank digit 1
      load_cfg(16'hAAAA, 4'h0, 4'b0010, 1'b0);
      step(1);
      check("aaaa_ready_low", {31'h0, bus.ready}, 32'h0);
      load_cfg(16'hBBBB, 4'h0, 4'h0, 1'b0);
      step(1);
      bus.load = 1'b0;
      check("bbbb_ready_low", {31'h0, bus.ready}, 32'h0);
      step(1);
      check("aaaa_fd", {31'h0, bus.frame_done}, 32'h1);
      check("aaaa_fd_ready", {31'h0, bus.ready}, 32'h0);
      step(1);
      check("aaaa_ready_rise", {31'h0, bus.ready}, 32'h1);
      step(1);  chk_disp("aaaa_d0", 4'hE, 4'hA);
      step(5);  chk_disp("aaaa_d1_blank", 4'hF, 4'hA);
      step(5);  chk_disp("aaaa_d2", 4'hB, 4'hA);
      step(5);  chk_disp("aaaa_d3", 4'h7, 4'hA);

      // Load on the frame_done cycle with pending=1 is dropped, next cycle taken
      load_cfg(16'h5678, 4'h0, 4'h0, 1'b0);
      step(1);
      bus.load = 1'b0;
      step(2);
      check("fdload_fd", {31'h0, bus.frame_done}, 32'h1);
      check("fdload_ready", {31'h0, bus.ready}, 32'h0);
      load_cfg(16'h9ABC, 4'h0, 4'h0, 1'b0);
      step(1);
      check("fdload_ready_pos0", {31'h0, bus.ready}, 32'h1);
      step(1);
      bus.load = 1'b0;
      check("fdload_accepted", {31'h0, bus.ready}, 32'h0);
      chk_disp("fdload_d0_5678", 4'hE, 4'h8);
      to_pos(1);
      chk_disp("fdload_d0_9abc", 4'hE, 4'hC);

      // en dropped during SHOW of digit 2
      load_cfg(16'h4321, 4'h0, 4'h0, 1'b0);
      step(1);
      bus.load = 1'b0;
      step(10);
      chk_disp("en_drop_d2", 4'hB, 4'hA);
      bus.en = 1'b0;
      step(1);
      check("en_low_an", {28'h0, bus.an}, 32'hF);
      check("en_low_commit", {31'h0, bus.ready}, 32'h1);
      step(3);
      check("en_low_an_hold", {28'h0, bus.an}, 32'hF);
      check("en_low_fd", {31'h0, bus.frame_done}, 32'h0);
      bus.en = 1'b1;
      wait_fd(k);
      check("reenable_fd_cycle", k + 1, PER);
      step(2);
      chk_disp("reenable_d0", 4'hE, 4'h1);

      // Asynchronous reset mid-SHOW with a pending load
      load_cfg(16'hFEDC, 4'h0, 4'h0, 1'b0);
      step(1);
      bus.load = 1'b0;
      check("rst_pending", {31'h0, bus.ready}, 32'h0);
      step(5);
      chk_disp("rst_pre_d1", 4'hD, 4'h2);
      #2 rst = 1'b1;
      #1;
      chk_disp("rst_async", 4'hF, 4'h0);
      check("rst_async_dp_n", {31'h0, bus.dp_n}, 32'h1);
      check("rst_async_ready", {31'h0, bus.ready}, 32'h1);
      check("rst_async_fd", {31'h0, bus.frame_done}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      step(1);
      chk_disp("rst_after_d0", 4'hE, 4'h0);
      check("rst_after_ready", {31'h0, bus.ready}, 32'h1);
      step(5);
      chk_disp("rst_after_d1", 4'hD, 4'h0);

      step(3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
